bfp_result_normalizer: RTL and testbench

//  Downstream of separate_sum_unit. Converts its two per-cycle block-floating-point results
//  ({exp[7:0], signed mant[23:0]}, lanes a/b) to bfloat16 for output writeback.
//  3-stage pipeline: abs/sign, leading-zero count + shift, exponent/round/pack.

---
 rtl/bfp_result_normalizer.sv | 202 ++++++++++++++++++++
 tb/tb_bfp_result_normalizer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfp_result_normalizer.sv
// bfp_result_normalizer: converts two block-floating-point lanes to bfloat16 in a 3-stage stallable pipeline.
// Define BFP_NORM_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module bfp_result_normalizer #(
  parameter int unsigned EXP_OFFSET = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          in_data_a_i,
  input  logic [31:0]          in_data_b_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [15:0]          out_data_a_o,
  output logic [15:0]          out_data_b_o,
  input  logic                 clr_i,
  output logic                 ovf_flag_o,
  output logic                 udf_flag_o,
  output logic [CNT_WIDTH-1:0] result_cnt_o
);

  localparam logic [10:0] EXP_OFF = 11'(EXP_OFFSET);

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
    logic        udf;
  } pack_t;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  // Exponent math is done in 11 bits so that exp + p - EXP_OFFSET never wraps;
  // underflow is judged before rounding, overflow after the rounding carry.
  function automatic pack_t pack_lane(input logic       sign,
                                      input logic       zero,
                                      input logic [6:0] frac,
                                      input logic       rnd,
                                      input logic [4:0] p,
                                      input logic [7:0] exp_f);
    pack_t       r;
    logic [10:0] e_raw;
    logic [10:0] e_rnd;
    logic [7:0]  frac_r;
    e_raw  = {3'b000, exp_f} + {6'b000000, p} - EXP_OFF;
    frac_r = {1'b0, frac} + {7'b0000000, rnd};
    e_rnd  = e_raw + {10'b0, frac_r[7]};
    r = '0;
    if (zero) begin
      r = '0;
    end else if (e_raw[10] || (e_raw == 11'd0)) begin
      r.data = {sign, 15'b0};
      r.udf  = 1'b1;
    end else if (e_rnd >= 11'd255) begin
      r.data = {sign, 8'hFE, 7'h7F};
      r.ovf  = 1'b1;
    end else begin
      r.data = {sign, e_rnd[7:0], frac_r[6:0]};
    end
    return r;
  endfunction

  logic             en;
  logic             s0_valid;
  logic             s1_valid;
  logic [1:0][31:0] lane_in;
  logic [1:0][15:0] lane_out;
  logic [1:0]       lane_ovf;
  logic [1:0]       lane_udf;

  assign en           = !out_valid_o || out_ready_i;
  assign in_ready_o   = en;
  assign lane_in      = {in_data_b_i, in_data_a_i};
  assign out_data_a_o = lane_out[0];
  assign out_data_b_o = lane_out[1];

  // Stage valids move together; a bubble travels as a cleared valid and is never collapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid    <= 1'b0;
      s1_valid    <= 1'b0;
      out_valid_o <= 1'b0;
    end else if (en) begin
      s0_valid    <= in_valid_i;
      s1_valid    <= s0_valid;
      out_valid_o <= s1_valid;
    end
  end

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic        s0_sign;
    logic [23:0] s0_mag;
    logic [7:0]  s0_exp;
    logic        s1_sign;
    logic        s1_zero;
    logic        s1_rnd;
    logic [6:0]  s1_frac;
    logic [4:0]  s1_p;
    logic [7:0]  s1_exp;
    logic [15:0] out_q;
    logic [23:0] mag_d;
    logic [4:0]  lzc_d;
    logic        lead_d;
    logic        rnd_d;
    logic [6:0]  frac_d;
    pack_t       res_d;

    always_comb begin
      mag_d = lane_in[l][23] ? ((~lane_in[l][23:0]) + 24'd1) : lane_in[l][23:0];
    end

    // After normalisation bit 23 holds the leading one, so its absence means a zero magnitude.
`ifdef BFP_NORM_RNE_EN
    logic [23:0] norm_d;
    always_comb begin
      lzc_d  = lzc24(s0_mag);
      norm_d = s0_mag << lzc_d;
      lead_d = norm_d[23];
      frac_d = norm_d[22:16];
      rnd_d  = norm_d[15] && ((|norm_d[14:0]) || norm_d[16]);
    end
`else
    logic [7:0] top_d;
    always_comb begin
      lzc_d  = lzc24(s0_mag);
      top_d  = 8'((s0_mag << lzc_d) >> 16);
      lead_d = top_d[7];
      frac_d = top_d[6:0];
      rnd_d  = 1'b0;
    end
`endif

    always_comb begin
      res_d = pack_lane(s1_sign, s1_zero, s1_frac, s1_rnd, s1_p, s1_exp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s0_sign <= 1'b0;
        s0_mag  <= '0;
        s0_exp  <= '0;
        s1_sign <= 1'b0;
        s1_zero <= 1'b1;
        s1_rnd  <= 1'b0;
        s1_frac <= '0;
        s1_p    <= '0;
        s1_exp  <= '0;
        out_q   <= '0;
      end else if (en) begin
        if (in_valid_i) begin
          s0_sign <= lane_in[l][23];
          s0_mag  <= mag_d;
          s0_exp  <= lane_in[l][31:24];
        end
        if (s0_valid) begin
          s1_sign <= s0_sign;
          s1_zero <= !lead_d;
          s1_rnd  <= rnd_d;
          s1_frac <= frac_d;
          s1_p    <= 5'd23 - lzc_d;
          s1_exp  <= s0_exp;
        end
        if (s1_valid) begin
          out_q <= res_d.data;
        end
      end
    end

    assign lane_out[l] = out_q;
    assign lane_ovf[l] = res_d.ovf;
    assign lane_udf[l] = res_d.udf;
  end

  // Flags latch on the transfer into the output register; the counter on the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag_o   <= 1'b0;
      udf_flag_o   <= 1'b0;
      result_cnt_o <= '0;
    end else if (clr_i) begin
      ovf_flag_o   <= 1'b0;
      udf_flag_o   <= 1'b0;
      result_cnt_o <= '0;
    end else begin
      if (en && s1_valid) begin
        ovf_flag_o <= ovf_flag_o || (|lane_ovf);
        udf_flag_o <= udf_flag_o || (|lane_udf);
      end
      if (out_valid_o && out_ready_i) begin
        result_cnt_o <= result_cnt_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_bfp_result_normalizer.sv
// Testbench for bfp_result_normalizer: vector table with a scoreboard queue, plus stall, latency and reset sequences.
module tb_bfp_result_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_a_i;
  logic [31:0] in_data_b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_data_a_o;
  logic [15:0] out_data_b_o;
  logic        clr_i;
  logic        ovf_flag_o;
  logic        udf_flag_o;
  logic [15:0] result_cnt_o;

  always #5 clk = ~clk;

  bfp_result_normalizer #(.EXP_OFFSET(0), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_a_i  (in_data_a_i),
    .in_data_b_i  (in_data_b_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_a_o (out_data_a_o),
    .out_data_b_o (out_data_b_o),
    .clr_i        (clr_i),
    .ovf_flag_o   (ovf_flag_o),
    .udf_flag_o   (udf_flag_o),
    .result_cnt_o (result_cnt_o)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_seen = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data = '0;
  logic [15:0] burst_exp[8] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080,
                                16'h40A0, 16'h40C0, 16'h40E0, 16'h4100};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] ea, input logic [15:0] eb, input logic ovf, input logic udf);
    vec_t v;
    v.name = nm; v.a = a; v.b = b; v.ea = ea; v.eb = eb; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] burstIn(input int k, input bit neg);
    logic [23:0] m;
    m = neg ? 24'(-(k + 1)) : 24'(k + 1);
    return {8'h7F, m};
  endfunction

  function automatic logic [31:0] burstExp(input int k);
    logic [15:0] p;
    p = burst_exp[k];
    return {p, 1'b1, p[14:0]};
  endfunction

  // Drives one pair starting at a falling edge and records its expected result once accepted.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expected);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid_i  = 1'b1;
    in_data_a_i = a;
    in_data_b_i = b;
    while (!in_ready_o && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready_o) checkOutput("accept_timeout", 32'(in_ready_o), 32'd1);
    exp_q.push_back(expected);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on every handshake and checks data holds during a stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev && out_valid_o)
        checkOutput("stall_hold", {out_data_a_o, out_data_b_o}, hold_data);
      if (out_valid_o && out_ready_i) begin
        n_seen <= n_seen + 1;
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          checkOutput("lane_a", {16'h0, out_data_a_o}, {16'h0, e[31:16]});
          checkOutput("lane_b", {16'h0, out_data_b_o}, {16'h0, e[15:0]});
        end
      end
      hold_prev <= out_valid_o && !out_ready_i;
      hold_data <= {out_data_a_o, out_data_b_o};
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen_before;
    rst_n       = 1'b0;
    in_valid_i  = 1'b0;
    in_data_a_i = '0;
    in_data_b_i = '0;
    out_ready_i = 1'b1;
    clr_i       = 1'b0;

    addVec("one",       32'h7F000001, 32'h7F000001, 16'h3F80, 16'h3F80, 1'b0, 1'b0);
    addVec("neg3_zero", 32'h7FFFFFFD, 32'h80000000, 16'hC040, 16'h0000, 1'b0, 1'b0);
    addVec("ovf_big",   32'hF0400000, 32'h7F000001, 16'h7F7F, 16'h3F80, 1'b1, 1'b0);
    addVec("udf_e0",    32'h3F000001, 32'h00000001, 16'h1F80, 16'h0000, 1'b0, 1'b1);
    addVec("e255_e254", 32'hFF000001, 32'hFE000001, 16'h7F7F, 16'h7F00, 1'b1, 1'b0);
    addVec("e1_neg_e0", 32'h01000001, 32'h00FFFFFF, 16'h0080, 16'h8000, 1'b0, 1'b1);
`ifdef BFP_NORM_RNE_EN
    addVec("round_tie", 32'h7F000183, 32'h7FFFFE7D, 16'h43C2, 16'hC3C2, 1'b0, 1'b0);
    addVec("min_max",   32'h7F800000, 32'h7F7FFFFF, 16'hCB00, 16'h4B00, 1'b0, 1'b0);
    addVec("rnd_ovf",   32'hE87FFFFF, 32'hE8000001, 16'h7F7F, 16'h7400, 1'b1, 1'b0);
`else
    addVec("round_tie", 32'h7F000183, 32'h7FFFFE7D, 16'h43C1, 16'hC3C1, 1'b0, 1'b0);
    addVec("min_max",   32'h7F800000, 32'h7F7FFFFF, 16'hCB00, 16'h4AFF, 1'b0, 1'b0);
    addVec("rnd_ovf",   32'hE87FFFFF, 32'hE8000001, 16'h7F7F, 16'h7400, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_out_data", {out_data_a_o, out_data_b_o}, 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready_o), 32'd1);
    checkOutput("rst_flags", {30'b0, ovf_flag_o, udf_flag_o}, 32'd0);
    checkOutput("rst_cnt", 32'(result_cnt_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < vecs.size(); i++) begin
      pulseClear();
      applyStimulus(vecs[i].a, vecs[i].b, {vecs[i].ea, vecs[i].eb});
      waitDrain();
      checkOutput({vecs[i].name, "_ovf"}, 32'(ovf_flag_o), 32'(vecs[i].ovf));
      checkOutput({vecs[i].name, "_udf"}, 32'(udf_flag_o), 32'(vecs[i].udf));
      checkOutput({vecs[i].name, "_cnt"}, 32'(result_cnt_o), 32'd1);
    end

    $display("[TB] latency");
    pulseClear();
    in_valid_i  = 1'b1;
    in_data_a_i = 32'h7F000001;
    in_data_b_i = 32'h7F000001;
    exp_q.push_back({16'h3F80, 16'h3F80});
    @(negedge clk);
    in_valid_i = 1'b0;
    checkOutput("lat_cycle1", 32'(out_valid_o), 32'd0);
    @(negedge clk);
    checkOutput("lat_cycle2", 32'(out_valid_o), 32'd0);
    @(negedge clk);
    checkOutput("lat_cycle3", 32'(out_valid_o), 32'd1);
    @(negedge clk);
    checkOutput("lat_cnt", 32'(result_cnt_o), 32'd1);
    waitDrain();

    $display("[TB] burst with stall");
    pulseClear();
    checkOutput("clr_cnt", 32'(result_cnt_o), 32'd0);
    seen_before = n_seen;
    fork
      begin
        for (int k = 0; k < 8; k++) applyStimulus(burstIn(k, 1'b0), burstIn(k, 1'b1), burstExp(k));
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checkOutput("stall_in_ready", 32'(in_ready_o), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;
      end
    join
    waitDrain();
    checkOutput("burst_cnt", 32'(result_cnt_o), 32'd8);
    checkOutput("burst_seen", 32'(n_seen - seen_before), 32'd8);

    $display("[TB] reset mid-burst");
    applyStimulus(32'hF0400000, 32'h00000001, {16'h7F7F, 16'h0000});
    waitDrain();
    checkOutput("pre_rst_ovf", 32'(ovf_flag_o), 32'd1);
    checkOutput("pre_rst_udf", 32'(udf_flag_o), 32'd1);
    @(negedge clk);
    in_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data_a_i = burstIn(k, 1'b0);
      in_data_b_i = burstIn(k, 1'b1);
      exp_q.push_back(burstExp(k));
      @(negedge clk);
    end
    rst_n      = 1'b0;
    in_valid_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("midrst_ovf", 32'(ovf_flag_o), 32'd0);
    checkOutput("midrst_udf", 32'(udf_flag_o), 32'd0);
    checkOutput("midrst_cnt", 32'(result_cnt_o), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    in_valid_i  = 1'b1;
    in_data_a_i = burstIn(0, 1'b0);
    in_data_b_i = burstIn(0, 1'b1);
    exp_q.push_back(burstExp(0));
    @(negedge clk);
    in_valid_i = 1'b0;
    checkOutput("postrst_cycle1", 32'(out_valid_o), 32'd0);
    @(negedge clk);
    checkOutput("postrst_cycle2", 32'(out_valid_o), 32'd0);
    @(negedge clk);
    checkOutput("postrst_cycle3", 32'(out_valid_o), 32'd1);
    waitDrain();
    checkOutput("postrst_cnt", 32'(result_cnt_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
